ldpc_bit_packer: RTL and testbench
==================================

Name: ldpc_bit_packer

Overview:
- Packs the serial hard-decision bit stream from the LDPC decoder into W_OUT-bit words, tagged per timeslot channel.
- Generalises the 2-timeslot bit-to-byte stage:
  - NCH timeslot windows instead of two.
  - Configurable word width and bit order.
  - Per-window word alignment.
  - Window-start pulses and a sticky error flag.
- Sits between the LDPC decoder output and the byte deinterleaver / TS demux.

Parameters:
- W_OUT, 8, output word width in bits; legal range 2..32.
- NCH, 2, number of timeslot windows; legal range 1..8.
- LSB_FIRST, 1, 1 = first received bit lands in word bit 0 (shift right); 0 = first bit lands in bit W_OUT-1 (shift left).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- bit_vld  in  1  decoder output bit valid
- bit_din  in  1  decoder output bit
- ch_win  in  NCH  per-channel timeslot window, one-hot or zero
- word_vld  out  1  one-cycle pulse, word_data/word_ch valid
- word_data  out  W_OUT  packed word, held until next word_vld
- word_ch  out  CHW  channel index of word; CHW = (NCH>1) ? $clog2(NCH) : 1
- word_first  out  1  qualifies word_vld: first word since window rise
- ch_start  out  NCH  one-cycle pulse, bit j set on first accepted bit of channel j's window
- err_sticky  out  2  bit0 = multiple windows high; bit1 = partial word lost or padded; cleared only by reset

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values: all outputs 0; shift register 0; bit counter 0; state IDLE; first-flag 1.
- Active channel:
  - Lowest set index of ch_win.
  - If more than one bit of ch_win is set in any cycle, set err_sticky[0]; the lowest index still wins.
- Accept condition: bit_vld & |ch_win.
- Accepted bit shifts into the shift register per LSB_FIRST; the counter (width $clog2(W_OUT)) increments.
- Word completion:
  - On the accept where counter == W_OUT-1, counter wraps to 0.
  - Next cycle: word_vld=1, word_data = full word, word_ch = active channel, word_first = first-flag.
  - First-flag then clears.
  - Latency from last bit accepted to word_vld is 1 cycle.
- State machine (one per block, not per channel):
  - IDLE: no window high. Counter held 0. On any ch_win high → FILL, latch channel index.
  - FILL, same channel still high: keep packing.
  - FILL, ch_win falls to 0: → IDLE.
  - FILL, active index changes: → FILL for the new channel in the same cycle.
  - FILL, on leaving the window with counter != 0: partial word handled per Optional Feature, and err_sticky[1] is set.
- A bit presented in the same cycle the window falls is not accepted.
- On channel change, a bit in the change cycle belongs to the new channel at counter 0.
- First-flag is set to 1 on every transition into a channel (from IDLE or from a different channel).
- ch_start[j] pulses the cycle after the first accepted bit following entry to channel j.
  - Replaces the raw ts_win & en strobe of the older block.
- Windows high without bit_vld: counter holds, no outputs change.
- word_data is not cleared between words.
- A flush word and a normal completion can never coincide, since W_OUT≥2.

Optional Feature:
- Macro: LDPC_PACK_FLUSH_EN.
- Defined:
  - On leaving a window with counter != 0, the next cycle emits word_vld with the partial bits.
  - Partial bits are aligned as if the missing bits were 0 (zero-padded at the not-yet-filled end per LSB_FIRST).
  - word_ch = old channel; the first-flag applies as normal.
- Undefined: the partial bits are discarded silently except for err_sticky[1]; no word_vld.
- Both cases: counter resets to 0.

Decomposition:
- Package ldpc_pack_pkg:
  - State enum (IDLE, FILL).
  - Function for CHW.
  - Err bit index constants (ERR_MULTI_WIN=0, ERR_PARTIAL=1).
- One natural sub-module: ldpc_pack_prio_enc.
  - Parametrised NCH priority encoder.
  - Outputs index, any, and multi.

Test Plan:
- NCH=2, W_OUT=8, LSB_FIRST=1; ch_win=01, 16 bits 1,0,1,0,0,0,0,0 then 0xFF pattern:
  - Two word_vld: word_data=0x05 then 0xFF.
  - word_ch=0; word_first=1 then 0.
  - ch_start[0] pulses once.
- LSB_FIRST=0; same first byte → word_data=0xA0.
- ch_win 01 for 3 bits, then directly 10 for 8 bits 0xC3:
  - One word, ch=1, data 0xC3, word_first=1.
  - err_sticky[1]=1.
  - With LDPC_PACK_FLUSH_EN: an extra ch=0 word precedes it, with the 3 bits zero-padded.
- ch_win=11 for one cycle → err_sticky[0]=1, bits packed to ch 0; the flag stays set until reset_n pulses.
- bit_vld gapped (1 of every 3 cycles) over 8 bits → single word_vld exactly 1 cycle after the 8th accepted bit.
- reset_n asserted mid-word after 5 bits → all outputs 0 immediately; after release a fresh 8-bit window yields a correct word with word_first=1.

Source files
------------

// File: rtl/ldpc_bit_packer_pkg.sv
// Shared types and constants for the LDPC hard-decision bit packer.
// Holds the FSM state encoding, error-bit positions and the channel-index width helper.
package ldpc_pack_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } pack_state_e;

    localparam int ERR_MULTI_WIN = 0;
    localparam int ERR_PARTIAL   = 1;

    function automatic int chw_of(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/ldpc_bit_packer_if.sv
// Bit-stream input and tagged word output bundle of the LDPC bit packer.
// master = decoder/consumer side, slave = packer side.
interface ldpc_bit_packer_if #(
    parameter int W_OUT = 8,
    parameter int NCH   = 2
);
    localparam int CHW = ldpc_pack_pkg::chw_of(NCH);

    logic             bit_vld;
    logic             bit_din;
    logic [NCH-1:0]   ch_win;
    logic             word_vld;
    logic [W_OUT-1:0] word_data;
    logic [CHW-1:0]   word_ch;
    logic             word_first;
    logic [NCH-1:0]   ch_start;
    logic [1:0]       err_sticky;

    modport master (
        output bit_vld, bit_din, ch_win,
        input  word_vld, word_data, word_ch, word_first, ch_start, err_sticky
    );

    modport slave (
        input  bit_vld, bit_din, ch_win,
        output word_vld, word_data, word_ch, word_first, ch_start, err_sticky
    );

endinterface

// File: rtl/ldpc_bit_packer_prio_enc.sv
// Lowest-index-wins priority encoder over the timeslot windows.
// Purely combinational; also flags when more than one window is raised.
module ldpc_pack_prio_enc
    import ldpc_pack_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CHW = chw_of(NCH)
) (
    input  logic [NCH-1:0] req,
    output logic [CHW-1:0] idx,
    output logic           any,
    output logic           multi
);

    always_comb begin
        idx = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (req[j]) idx = CHW'(j);
        end
    end

    assign any   = |req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = (req & (req - NCH'(1))) != '0;

endmodule

// File: rtl/ldpc_bit_packer.sv
// Packs the decoder's serial bits into W_OUT-bit words per timeslot window; LDPC_PACK_FLUSH_EN emits padded partial words.
// Word appears 1 cycle after its last bit is accepted; no backpressure, the decoder stream is never stalled.
module ldpc_bit_packer
    import ldpc_pack_pkg::*;
#(
    parameter int W_OUT     = 8,
    parameter int NCH       = 2,
    parameter int LSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    ldpc_bit_packer_if.slave bus
);

    localparam int CHW = chw_of(NCH);
    localparam int CW  = $clog2(W_OUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(W_OUT - 1);
    localparam logic [0:0]    ST_IDLE  = 1'(IDLE);
    localparam logic [0:0]    ST_FILL  = 1'(FILL);

    logic [0:0]       state;
    logic [CHW-1:0]   cur_ch;
    logic [CW-1:0]    cnt;
    logic [W_OUT-1:0] sr;
    logic             first_flag;
    logic             start_pend;

    logic             word_vld_r;
    logic [W_OUT-1:0] word_data_r;
    logic [CHW-1:0]   word_ch_r;
    logic             word_first_r;
    logic [NCH-1:0]   ch_start_r;
    logic [1:0]       err_r;

    logic [CHW-1:0]   act_idx;
    logic             act_any;
    logic             act_multi;
    logic             in_fill;
    logic             enter;
    logic             leave;
    logic             accept;
    logic             complete;
    logic             partial;
    logic [CW-1:0]    cnt_base;
    logic [W_OUT-1:0] sr_next;

    ldpc_pack_prio_enc #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_prio (
        .req   (bus.ch_win),
        .idx   (act_idx),
        .any   (act_any),
        .multi (act_multi)
    );

    assign in_fill  = (state == ST_FILL);
    assign leave    = in_fill && (!act_any || (act_idx != cur_ch));
    assign enter    = act_any && (!in_fill || (act_idx != cur_ch));
    assign accept   = bus.bit_vld && act_any;
    // A channel switch restarts packing, so the switch-cycle bit lands at count 0.
    assign cnt_base = enter ? '0 : cnt;
    assign complete = accept && (cnt_base == CNT_LAST);
    assign partial  = leave && (cnt != '0);

`ifdef LDPC_PACK_FLUSH_EN
    localparam logic [CW:0] W_FULL = (CW + 1)'(W_OUT);
    logic [CW:0]      pad_sh;
    logic [W_OUT-1:0] pad_word;
    assign pad_sh = W_FULL - {1'b0, cnt};
`endif

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign sr_next = {bus.bit_din, sr[W_OUT-1:1]};
`ifdef LDPC_PACK_FLUSH_EN
            assign pad_word = sr >> pad_sh;
`endif
        end else begin : g_msb
            assign sr_next = {sr[W_OUT-2:0], bus.bit_din};
`ifdef LDPC_PACK_FLUSH_EN
            assign pad_word = sr << pad_sh;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cur_ch       <= '0;
            cnt          <= '0;
            sr           <= '0;
            first_flag   <= 1'b1;
            start_pend   <= 1'b0;
            word_vld_r   <= 1'b0;
            word_data_r  <= '0;
            word_ch_r    <= '0;
            word_first_r <= 1'b0;
            ch_start_r   <= '0;
            err_r        <= '0;
        end else begin
            word_vld_r <= 1'b0;
            ch_start_r <= '0;

            if (act_multi) err_r[ERR_MULTI_WIN] <= 1'b1;

            if (partial) begin
                err_r[ERR_PARTIAL] <= 1'b1;
`ifdef LDPC_PACK_FLUSH_EN
                word_vld_r   <= 1'b1;
                word_data_r  <= pad_word;
                word_ch_r    <= cur_ch;
                word_first_r <= first_flag;
`endif
            end

            if (!act_any) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                state      <= ST_FILL;
                start_pend <= (enter || start_pend) && !accept;
                if (enter) begin
                    cur_ch     <= act_idx;
                    first_flag <= 1'b1;
                end
                if (accept) begin
                    sr <= sr_next;
                    if (enter || start_pend) ch_start_r <= NCH'(1) << act_idx;
                    if (complete) begin
                        cnt          <= '0;
                        word_vld_r   <= 1'b1;
                        word_data_r  <= sr_next;
                        word_ch_r    <= act_idx;
                        word_first_r <= first_flag;
                        first_flag   <= 1'b0;
                    end else begin
                        cnt <= cnt_base + CW'(1);
                    end
                end else begin
                    cnt <= cnt_base;
                end
            end
        end
    end

    assign bus.word_vld   = word_vld_r;
    assign bus.word_data  = word_data_r;
    assign bus.word_ch    = word_ch_r;
    assign bus.word_first = word_first_r;
    assign bus.ch_start   = ch_start_r;
    assign bus.err_sticky = err_r;

endmodule

// File: tb/tb_ldpc_bit_packer.sv
// Bench for ldpc_bit_packer: LSB-first and MSB-first instances share one input stream.
// A queue-based word model predicts every output cycle by cycle.
module tb_ldpc_bit_packer;
    import ldpc_pack_pkg::*;

    localparam int W   = 8;
    localparam int NCH = 2;
    localparam int CHW = chw_of(NCH);
    localparam int OW  = 1 + W + CHW + 1 + NCH + 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ldpc_bit_packer_if #(.W_OUT(W), .NCH(NCH)) ifa ();
    ldpc_bit_packer_if #(.W_OUT(W), .NCH(NCH)) ifb ();

    assign ifb.bit_vld = ifa.bit_vld;
    assign ifb.bit_din = ifa.bit_din;
    assign ifb.ch_win  = ifa.ch_win;

    ldpc_bit_packer #(.W_OUT(W), .NCH(NCH), .LSB_FIRST(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    ldpc_bit_packer #(.W_OUT(W), .NCH(NCH), .LSB_FIRST(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    wire [OW-1:0] obs_a = {ifa.word_vld, ifa.word_data, ifa.word_ch, ifa.word_first, ifa.ch_start, ifa.err_sticky};
    wire [OW-1:0] obs_b = {ifb.word_vld, ifb.word_data, ifb.word_ch, ifb.word_first, ifb.ch_start, ifb.err_sticky};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    bit             q[$];
    int             cur;
    bit             mfirst;
    bit             pend;
    logic           exp_vld;
    logic [W-1:0]   exp_da, exp_db;
    logic [CHW-1:0] exp_ch;
    logic           exp_first;
    logic [NCH-1:0] exp_start;
    logic [1:0]     exp_err;

    wire [OW-1:0] exp_a = {exp_vld, exp_da, exp_ch, exp_first, exp_start, exp_err};
    wire [OW-1:0] exp_b = {exp_vld, exp_db, exp_ch, exp_first, exp_start, exp_err};

    function automatic logic [W-1:0] pack(input bit lsb);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (lsb) r[i] = q[i];
            else     r[W-1-i] = q[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        cur = -1; mfirst = 1'b1; pend = 1'b0;
        exp_vld = 0; exp_da = '0; exp_db = '0; exp_ch = '0;
        exp_first = 0; exp_start = '0; exp_err = '0;
    endtask

    task automatic model_clock(input logic v, input logic d, input logic [NCH-1:0] w);
        int idx;
        idx = -1;
        exp_vld = 1'b0;
        exp_start = '0;
        for (int j = NCH - 1; j >= 0; j--) if (w[j]) idx = j;
        if ($countones(w) > 1) exp_err[0] = 1'b1;
        if (cur >= 0 && idx != cur) begin
            if (q.size() != 0) begin
                exp_err[1] = 1'b1;
`ifdef LDPC_PACK_FLUSH_EN
                exp_vld = 1'b1; exp_da = pack(1'b1); exp_db = pack(1'b0);
                exp_ch = CHW'(cur); exp_first = mfirst;
`endif
                q.delete();
            end
            cur = -1;
        end
        if (idx >= 0 && cur != idx) begin
            cur = idx; mfirst = 1'b1; pend = 1'b1; q.delete();
        end
        if (v && idx >= 0) begin
            q.push_back(d);
            if (pend) begin exp_start[idx] = 1'b1; pend = 1'b0; end
            if (q.size() == W) begin
                exp_vld = 1'b1; exp_da = pack(1'b1); exp_db = pack(1'b0);
                exp_ch = CHW'(cur); exp_first = mfirst; mfirst = 1'b0;
                q.delete();
            end
        end
    endtask

    // Inputs change at negedge; DUT and model both see them at the next posedge.
    task automatic step(input logic v, input logic d, input logic [NCH-1:0] w);
        ifa.bit_vld = v; ifa.bit_din = d; ifa.ch_win = w;
        @(posedge clk);
        model_clock(v, d, w);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ifa.bit_vld = 0; ifa.bit_din = 0; ifa.ch_win = '0;
        model_reset();
        repeat (3) @(negedge clk);
        if (obs_a !== '0 || obs_b !== '0) begin
            errors++; $display("FAIL reset_state a=%h b=%h required 0", obs_a, obs_b);
        end
        checks++;
        reset_n = 1'b1;
        step(0, 0, '0);
        if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++; $display("FAIL after_release a=%h/%h b=%h/%h", obs_a, exp_a, obs_b, exp_b);
        end
        checks++;
    endtask

    task automatic test_basic();
        logic [15:0] pat;
        logic [W-1:0] wa[$], wb[$];
        logic fa[$];
        int starts;
        pat = 16'hFF05;
        starts = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) step(1, pat[i], 2'b01); else step(0, 0, '0);
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++; $display("FAIL basic cyc=%0d a=%h/%h b=%h/%h", cyc, obs_a, exp_a, obs_b, exp_b);
            end
            checks++;
            if (ifa.word_vld) begin wa.push_back(ifa.word_data); fa.push_back(ifa.word_first); end
            if (ifb.word_vld) wb.push_back(ifb.word_data);
            starts += $countones(ifa.ch_start);
        end
        if (wa.size() != 2 || wb.size() != 2) begin
            errors++; $display("FAIL basic_count got %0d/%0d required 2/2", wa.size(), wb.size());
        end else if (wa[0] !== 8'h05 || wa[1] !== 8'hFF || wb[0] !== 8'hA0 || fa[0] !== 1'b1 || fa[1] !== 1'b0) begin
            errors++;
            $display("FAIL basic_words got %h %h msb %h first %b%b required 05 ff a0 10", wa[0], wa[1], wb[0], fa[0], fa[1]);
        end
        checks++;
        if (starts != 1) begin
            errors++; $display("FAIL basic_ch_start got %0d pulses required 1", starts);
        end
        checks++;
    endtask

    task automatic test_ch_change();
        logic [7:0] pat;
        logic [W-1:0] wa[$], wb[$];
        logic [CHW-1:0] wc[$];
        logic wf[$];
        int nexp;
        pat = 8'hC3;
        for (int i = 0; i < 13; i++) begin
            if (i < 3)       step(1, 1, 2'b01);
            else if (i < 11) step(1, pat[i-3], 2'b10);
            else             step(0, 0, '0);
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++; $display("FAIL ch_change cyc=%0d a=%h/%h b=%h/%h", cyc, obs_a, exp_a, obs_b, exp_b);
            end
            checks++;
            if (ifa.word_vld) begin
                wa.push_back(ifa.word_data); wb.push_back(ifb.word_data);
                wc.push_back(ifa.word_ch); wf.push_back(ifa.word_first);
            end
        end
`ifdef LDPC_PACK_FLUSH_EN
        nexp = 2;
`else
        nexp = 1;
`endif
        if (wa.size() != nexp) begin
            errors++; $display("FAIL ch_change_count got %0d required %0d", wa.size(), nexp);
        end else begin
            if (wa[nexp-1] !== 8'hC3 || wb[nexp-1] !== 8'hC3 || wc[nexp-1] !== 1'b1 || wf[nexp-1] !== 1'b1) begin
                errors++;
                $display("FAIL ch_change_word got %h/%h ch%0d first%b required c3/c3 ch1 first1",
                         wa[nexp-1], wb[nexp-1], wc[nexp-1], wf[nexp-1]);
            end
            checks++;
`ifdef LDPC_PACK_FLUSH_EN
            if (wa[0] !== 8'h07 || wb[0] !== 8'hE0 || wc[0] !== 1'b0) begin
                errors++; $display("FAIL flush_word got %h/%h ch%0d required 07/e0 ch0", wa[0], wb[0], wc[0]);
            end
            checks++;
`endif
        end
        checks++;
        if (ifa.err_sticky[ERR_PARTIAL] !== 1'b1) begin
            errors++; $display("FAIL partial_err got %b required 1", ifa.err_sticky[ERR_PARTIAL]);
        end
        checks++;
    endtask

    task automatic test_multi();
        logic [CHW-1:0] ch_seen;
        int nw;
        nw = 0; ch_seen = '1;
        for (int i = 0; i < 30; i++) begin
            if (i == 0)     step(1, 1, 2'b11);
            else if (i < 8) step(1, 1'($urandom_range(0, 1)), 2'b01);
            else            step(0, 0, '0);
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++; $display("FAIL multi cyc=%0d a=%h/%h b=%h/%h", cyc, obs_a, exp_a, obs_b, exp_b);
            end
            checks++;
            if (ifa.word_vld) begin nw++; ch_seen = ifa.word_ch; end
        end
        if (nw != 1 || ch_seen !== 1'b0 || ifa.err_sticky[ERR_MULTI_WIN] !== 1'b1) begin
            errors++; $display("FAIL multi_win words=%0d ch=%0d err0=%b required 1 word ch0 err0=1",
                               nw, ch_seen, ifa.err_sticky[ERR_MULTI_WIN]);
        end
        checks++;
    endtask

    task automatic test_gapped();
        logic [7:0] pat;
        int acc_cyc, vld_cyc, nw;
        pat = 8'($urandom);
        acc_cyc = -1; vld_cyc = -1; nw = 0;
        for (int i = 0; i < 26; i++) begin
            if (i < 24 && (i % 3) == 0) begin
                if (i == 21) acc_cyc = cyc;
                step(1, pat[i/3], 2'b10);
            end else if (i < 24) begin
                step(0, 1'($urandom_range(0, 1)), 2'b10);
            end else begin
                step(0, 0, '0);
            end
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++; $display("FAIL gapped cyc=%0d a=%h/%h b=%h/%h", cyc, obs_a, exp_a, obs_b, exp_b);
            end
            checks++;
            if (ifa.word_vld) begin nw++; vld_cyc = cyc; end
        end
        if (nw != 1 || vld_cyc - acc_cyc != 1) begin
            errors++; $display("FAIL gapped_latency words=%0d latency=%0d required 1 word latency 1", nw, vld_cyc - acc_cyc);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [NCH-1:0] w;
        w = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: w = 2'b00;
                    3, 4, 5: w = 2'b01;
                    9:       w = 2'b11;
                    default: w = 2'b10;
                endcase
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), w);
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++; $display("FAIL random cyc=%0d a=%h/%h b=%h/%h", cyc, obs_a, exp_a, obs_b, exp_b);
            end
            checks++;
        end
        step(0, 0, '0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] pat;
        int nw;
        logic [W-1:0] wd;
        logic wf;
        pat = 8'($urandom);
        nw = 0; wd = '0; wf = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 1'($urandom_range(0, 1)), 2'b01);
        #2 reset_n = 1'b0;
        #1;
        if (obs_a !== '0 || obs_b !== '0) begin
            errors++; $display("FAIL reset_mid a=%h b=%h required 0", obs_a, obs_b);
        end
        checks++;
        model_reset();
        ifa.bit_vld = 0; ifa.bit_din = 0; ifa.ch_win = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1, pat[i], 2'b10); else step(0, 0, '0);
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++; $display("FAIL post_reset cyc=%0d a=%h/%h b=%h/%h", cyc, obs_a, exp_a, obs_b, exp_b);
            end
            checks++;
            if (ifa.word_vld) begin nw++; wd = ifa.word_data; wf = ifa.word_first; end
        end
        if (nw != 1 || wd !== pat || wf !== 1'b1 || ifa.err_sticky !== 2'b00) begin
            errors++; $display("FAIL post_reset_word words=%0d data=%h first=%b err=%b required 1 %h 1 00",
                               nw, wd, wf, ifa.err_sticky, pat);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ch_change();
        test_multi();
        test_gapped();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
